// File: rtl/dbg_dump_pkg.sv
// Shared types and constants for the RAM-to-UART debug dumper.
// DBG_DUMP_ADDR_EN adds a 2-byte address prefix to every dumped word.
package dbg_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    FETCH,
    WAIT,
    SEND,
    NEXT,
    DONE
  } dump_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         UART_FRAME_BITS   = 10;

`ifdef DBG_DUMP_ADDR_EN
  localparam int BYTES_PER_WORD = 6;
`else
  localparam int BYTES_PER_WORD = 4;
`endif

  localparam int WORD_BITS = BYTES_PER_WORD * 8;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter for one byte at a time; o_ready rises during the last
// stop-bit cycle so a waiting byte follows with no idle bits in between.
module uart_tx_byte
  import dbg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]        LAST_BIT  = 4'(UART_FRAME_BITS - 1);

  logic             active_reg;
  logic [3:0]       bit_idx_reg;
  logic [CNT_W-1:0] baud_cnt_reg;
  logic [8:0]       shift_reg;
  logic             tx_reg;
  logic             ready_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      active_reg   <= 1'b0;
      bit_idx_reg  <= '0;
      baud_cnt_reg <= '0;
      shift_reg    <= '1;
      tx_reg       <= 1'b1;
      ready_reg    <= 1'b1;
    end else if (i_valid && ready_reg) begin
      // Stop bit is parked in shift_reg[8] so it falls out after the data bits.
      active_reg   <= 1'b1;
      bit_idx_reg  <= '0;
      baud_cnt_reg <= '0;
      shift_reg    <= {1'b1, i_data};
      tx_reg       <= 1'b0;
      ready_reg    <= 1'b0;
    end else if (active_reg) begin
      if (baud_cnt_reg == BAUD_LAST) begin
        baud_cnt_reg <= '0;
        if (bit_idx_reg == LAST_BIT) begin
          active_reg <= 1'b0;
        end else begin
          bit_idx_reg <= bit_idx_reg + 4'd1;
          tx_reg      <= shift_reg[0];
          shift_reg   <= {1'b1, shift_reg[8:1]};
        end
      end else begin
        baud_cnt_reg <= baud_cnt_reg + 1'b1;
        if (bit_idx_reg == LAST_BIT && baud_cnt_reg == BAUD_PRE) begin
          ready_reg <= 1'b1;
        end
      end
    end
  end

  assign o_ready = ready_reg;
  assign o_tx    = tx_reg;

endmodule

// File: rtl/dbg_dump_uart_tx.sv
// Walks a word-aligned RAM range and streams a sync byte plus every word over UART.
// Define DBG_DUMP_ADDR_EN to prefix each word with its 16-bit address.
module dbg_dump_uart_tx
  import dbg_dump_pkg::*;
#(
  parameter int         ADDR_W       = 16,
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  output logic              o_mem_rd_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [31:0]       i_mem_rd_data,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

  dump_state_t          state_reg;
  logic [ADDR_W-1:0]    cur_addr_reg;
  logic [ADDR_W-1:0]    end_addr_reg;
  logic [ADDR_W-1:0]    mem_addr_reg;
  logic                 rd_en_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic [WORD_BITS-1:0] shift_reg;
  logic [2:0]           bytes_left_reg;
  logic                 tx_valid_reg;

  logic                 tx_valid;
  logic [7:0]           tx_data;
  logic                 tx_ready;
  logic [WORD_BITS-1:0] word_next;

`ifdef DBG_DUMP_ADDR_EN
  assign word_next = {16'(cur_addr_reg), i_mem_rd_data};
`else
  assign word_next = i_mem_rd_data;
`endif

  // The first byte of a word goes straight from the RAM port so the start bit
  // leaves on the WAIT edge; the uart is always idle at that point.
  always_comb begin
    tx_valid = tx_valid_reg;
    tx_data  = shift_reg[WORD_BITS-1 -: 8];
    case (state_reg)
      SYNC: tx_data = SYNC_BYTE;
      WAIT: begin
        tx_valid = 1'b1;
        tx_data  = word_next[WORD_BITS-1 -: 8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      cur_addr_reg   <= '0;
      end_addr_reg   <= '0;
      mem_addr_reg   <= '0;
      rd_en_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      shift_reg      <= '0;
      bytes_left_reg <= '0;
      tx_valid_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            cur_addr_reg   <= i_start_addr & ALIGN_MASK;
            end_addr_reg   <= i_end_addr & ALIGN_MASK;
            busy_reg       <= 1'b1;
            bytes_left_reg <= 3'd1;
            tx_valid_reg   <= 1'b0;
            state_reg      <= SYNC;
          end
        end
        SYNC: begin
          if (bytes_left_reg != 3'd0) begin
            if (!tx_valid_reg) begin
              tx_valid_reg <= 1'b1;
            end else if (tx_ready) begin
              tx_valid_reg   <= 1'b0;
              bytes_left_reg <= 3'd0;
            end
          end else if (tx_ready) begin
            if (cur_addr_reg <= end_addr_reg) begin
              rd_en_reg    <= 1'b1;
              mem_addr_reg <= cur_addr_reg;
              state_reg    <= FETCH;
            end else begin
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= DONE;
            end
          end
        end
        FETCH: begin
          rd_en_reg <= 1'b0;
          state_reg <= WAIT;
        end
        WAIT: begin
          shift_reg      <= word_next << 8;
          bytes_left_reg <= 3'(BYTES_PER_WORD - 1);
          tx_valid_reg   <= 1'b1;
          state_reg      <= SEND;
        end
        SEND: begin
          // A ready uart with nothing queued means the last stop bit just ended.
          if (tx_valid_reg) begin
            if (tx_ready) begin
              shift_reg      <= shift_reg << 8;
              bytes_left_reg <= bytes_left_reg - 3'd1;
              if (bytes_left_reg == 3'd1) tx_valid_reg <= 1'b0;
            end
          end else if (tx_ready) begin
            state_reg <= NEXT;
          end
        end
        NEXT: begin
          if (cur_addr_reg == end_addr_reg) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end else begin
            cur_addr_reg <= cur_addr_reg + WORD_STEP;
            mem_addr_reg <= cur_addr_reg + WORD_STEP;
            rd_en_reg    <= 1'b1;
            state_reg    <= FETCH;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(tx_valid),
    .i_data (tx_data),
    .o_ready(tx_ready),
    .o_tx   (o_tx)
  );

  assign o_mem_rd_en = rd_en_reg;
  assign o_mem_addr  = mem_addr_reg;
  assign o_busy      = busy_reg;
  assign o_done      = done_reg;

endmodule

// File: tb/tb_dbg_dump_uart_tx.sv
// Scoreboard bench for dbg_dump_uart_tx: expected UART bytes and RAM reads are
// queued by the stimulus and popped by independent monitors.
module tb_dbg_dump_uart_tx;

  localparam int CPB = 4;

`ifdef DBG_DUMP_ADDR_EN
  localparam int T_ONE   = 285;
  localparam int T_FIVE  = 1257;
`else
  localparam int T_ONE   = 205;
  localparam int T_FIVE  = 857;
`endif
  localparam int T_EMPTY = 42;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] end_addr = '0;
  logic        rd_en;
  logic [15:0] mem_addr;
  logic [31:0] rd_data = '0;
  logic        tx;
  logic        busy;
  logic        done;

  int vec_cnt = 0;
  int err_cnt = 0;
  int done_pulses = 0;

  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_addrs[$];

  always #5 clk = ~clk;

  dbg_dump_uart_tx #(
    .ADDR_W(16),
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_start_addr (start_addr),
    .i_end_addr   (end_addr),
    .o_mem_rd_en  (rd_en),
    .o_mem_addr   (mem_addr),
    .i_mem_rd_data(rd_data),
    .o_tx         (tx),
    .o_busy       (busy),
    .o_done       (done)
  );

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    if (a == 16'h7FEC) return 32'hDEADBEEF;
    if (a == 16'hFFFC) return 32'h01234567;
    return {a, ~a};
  endfunction

  always @(posedge clk) begin
    if (rd_en) rd_data <= ram_word(mem_addr);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  task automatic push_word(input logic [15:0] a);
    logic [31:0] d;
    d = ram_word(a);
    exp_addrs.push_back(a);
`ifdef DBG_DUMP_ADDR_EN
    exp_bytes.push_back(a[15:8]);
    exp_bytes.push_back(a[7:0]);
`endif
    exp_bytes.push_back(d[31:24]);
    exp_bytes.push_back(d[23:16]);
    exp_bytes.push_back(d[15:8]);
    exp_bytes.push_back(d[7:0]);
  endtask

  // UART decoder: samples mid-bit on the falling edge, abandons a frame on reset.
  initial begin : uart_monitor
    logic [7:0] b;
    logic       stop;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        aborted = 1'b0;
        b = '0;
        stop = 1'b0;
        for (int c = 1; c <= 9*CPB + CPB/2; c++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (c > CPB && c < 9*CPB && (c % CPB) == CPB/2) b[c/CPB - 1] = tx;
          if (c == 9*CPB + CPB/2) stop = tx;
        end
        if (!aborted) begin
          check("stop_bit", {31'd0, stop}, 32'd1);
          if (exp_bytes.size() == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_byte: got 0x%0h, required none", b);
          end else begin
            check("uart_byte", {24'd0, b}, {24'd0, exp_bytes.pop_front()});
          end
        end
      end
    end
  end

  initial begin : rd_monitor
    forever begin
      @(negedge clk);
      if (!rst && rd_en === 1'b1) begin
        if (exp_addrs.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL unexpected_read: got 0x%0h, required none", mem_addr);
        end else begin
          check("rd_addr", {16'd0, mem_addr}, {16'd0, exp_addrs.pop_front()});
        end
      end
    end
  end

  initial begin : done_monitor
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_pulses++;
    end
  end

  task automatic do_dump(input logic [15:0] sa, input logic [15:0] ea,
                         input int exp_cyc, input int restart_at);
    int cyc;
    int d0;
    d0 = done_pulses;
    @(posedge clk); #1;
    start_addr = sa;
    end_addr   = ea;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    start_addr = 16'h1234;
    end_addr   = 16'h0000;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      start = (cyc == restart_at);
      if (done === 1'b1 || cyc >= 5000) break;
    end
    start = 1'b0;
    check("done_cycle", cyc, exp_cyc);
    repeat (20) @(posedge clk);
    #1;
    check("done_pulses", done_pulses - d0, 1);
    check("bytes_left", exp_bytes.size(), 0);
    check("reads_left", exp_addrs.size(), 0);
    check("busy_after", {31'd0, busy}, 0);
  endtask

  initial begin : stimulus
    int bad;
    repeat (5) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_rd_en", {31'd0, rd_en}, 0);
    check("rst_addr", {16'd0, mem_addr}, 0);
    rst = 1'b0;

    // single word, hand-listed stream
    exp_bytes.push_back(8'hA5);
`ifdef DBG_DUMP_ADDR_EN
    exp_bytes.push_back(8'h7F);
    exp_bytes.push_back(8'hEC);
`endif
    exp_bytes.push_back(8'hDE);
    exp_bytes.push_back(8'hAD);
    exp_bytes.push_back(8'hBE);
    exp_bytes.push_back(8'hEF);
    exp_addrs.push_back(16'h7FEC);
    do_dump(16'h7FEC, 16'h7FEC, T_ONE, -1);

    // five words, end address low bits ignored
    exp_bytes.push_back(8'hA5);
    push_word(16'h7FEC);
    push_word(16'h7FF0);
    push_word(16'h7FF4);
    push_word(16'h7FF8);
    push_word(16'h7FFC);
    do_dump(16'h7FEC, 16'h7FFF, T_FIVE, -1);

    // second start while busy is ignored
    exp_bytes.push_back(8'hA5);
    push_word(16'h7FEC);
    do_dump(16'h7FEC, 16'h7FEC, T_ONE, 50);

    // empty range: sync byte only
    exp_bytes.push_back(8'hA5);
    do_dump(16'h0010, 16'h000C, T_EMPTY, -1);

    // top of address space terminates without wrapping
    exp_bytes.push_back(8'hA5);
    push_word(16'hFFFC);
    do_dump(16'hFFFC, 16'hFFFC, T_ONE, -1);

    // reset in the middle of a dump
    exp_bytes.push_back(8'hA5);
    push_word(16'h7FEC);
    push_word(16'h7FF0);
    push_word(16'h7FF4);
    @(posedge clk); #1;
    start_addr = 16'h7FEC;
    end_addr   = 16'h7FF4;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_tx", {31'd0, tx}, 1);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_rd_en", {31'd0, rd_en}, 0);
    repeat (2) @(posedge clk);
    #1;
    exp_bytes.delete();
    exp_addrs.delete();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) bad++;
    end
    check("quiet_after_rst", bad, 0);

    // clean dump after reset
    exp_bytes.push_back(8'hA5);
    push_word(16'h7FEC);
    do_dump(16'h7FEC, 16'h7FEC, T_ONE, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
